// File: rtl/instr_fetch_window.sv
// Instruction byte window: buffers a 32-bit byte stream and presents the oldest
// 12 bytes, little-endian, to the prefix/opcode decode stage.
//
// state   | meaning
// --------+-----------------------------------------------
// FILL    | stream open, fewer than 12 bytes buffered
// PRESENT | 12 or more bytes buffered, full window valid
// DRAIN   | stream ended, 1..11 bytes left to present
// DONE    | stream ended, buffer empty; only flush leaves
module instr_fetch_window #(
    parameter int WINDOW_BYTES = 12,
    parameter int IN_BYTES     = 4,
    parameter int BUF_BYTES    = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [IN_BYTES*8-1:0]     in_data,
    input  logic                      in_last,
    input  logic                      flush,
    input  logic [31:0]               flush_offset,
    output logic                      out_valid,
    output logic [WINDOW_BYTES*8-1:0] out_raw_instr,
    output logic [3:0]                out_bytes_avail,
    output logic [31:0]               out_offset,
    input  logic                      consume,
    input  logic [3:0]                consume_len,
    output logic                      err_consume
);

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        PRESENT = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int BUF_BITS = BUF_BYTES * 8;

    state_t                state_q, state_nxt;
    logic [BUF_BITS-1:0]   byte_buf_q, byte_buf_nxt, shifted;
    logic [4:0]            count_q, count_nxt, count_s;
    logic                  eos_q, eos_nxt;
    logic [31:0]           offset_q, offset_nxt;
    logic                  err_q, err_nxt;
    logic                  ready_q, ready_nxt;
    logic [3:0]            avail_q, avail_nxt;
    logic [3:0]            shift_len;
    logic                  legal, accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FILL;
            byte_buf_q <= '0;
            count_q    <= '0;
            eos_q      <= 1'b0;
            offset_q   <= '0;
            err_q      <= 1'b0;
            ready_q    <= 1'b0;
            avail_q    <= '0;
        end else begin
            state_q    <= state_nxt;
            byte_buf_q <= byte_buf_nxt;
            count_q    <= count_nxt;
            eos_q      <= eos_nxt;
            offset_q   <= offset_nxt;
            err_q      <= err_nxt;
            ready_q    <= ready_nxt;
            avail_q    <= avail_nxt;
        end
    end

    always_comb begin
        legal     = consume && out_valid && (consume_len != 4'd0) &&
                    (consume_len <= avail_q);
        accept    = in_valid && ready_q && !flush;
        shift_len = legal ? consume_len : 4'd0;

        // Retire consumed bytes first so a same-cycle beat lands right after the survivors.
        shifted      = byte_buf_q >> {shift_len, 3'b000};
        count_s      = count_q - {1'b0, shift_len};
        byte_buf_nxt = shifted;
        count_nxt    = count_s;
        if (accept) begin
            byte_buf_nxt = shifted |
                ({{(BUF_BYTES-IN_BYTES)*8{1'b0}}, in_data} << {count_s, 3'b000});
            count_nxt    = count_s + 5'(IN_BYTES);
        end
        eos_nxt    = eos_q || (accept && in_last);
        offset_nxt = offset_q + {28'd0, shift_len};
        err_nxt    = consume && !legal;

        if (flush) begin
            byte_buf_nxt = '0;
            count_nxt    = '0;
            eos_nxt      = 1'b0;
            offset_nxt   = flush_offset;
            err_nxt      = 1'b0;
        end

        if (count_nxt >= 5'(WINDOW_BYTES))
            state_nxt = PRESENT;
        else if (!eos_nxt)
            state_nxt = FILL;
        else if (count_nxt == 5'd0)
            state_nxt = DONE;
        else
            state_nxt = DRAIN;

        ready_nxt = (count_nxt <= 5'(WINDOW_BYTES)) && !eos_nxt;
        avail_nxt = (count_nxt > 5'(WINDOW_BYTES)) ? 4'(WINDOW_BYTES) : count_nxt[3:0];
    end

    assign in_ready        = ready_q;
    assign out_valid       = (state_q == PRESENT) || (state_q == DRAIN);
    assign out_raw_instr   = byte_buf_q[WINDOW_BYTES*8-1:0];
    assign out_bytes_avail = avail_q;
    assign out_offset      = offset_q;
    assign err_consume     = err_q;

endmodule

// File: tb/tb_instr_fetch_window.sv
// Directed bench for instr_fetch_window: each step queues its expected outputs,
// then pops and compares them one cycle after the stimulus edge.
module tb_instr_fetch_window;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] flush_offset = '0;
    logic        out_valid;
    logic [95:0] out_raw_instr;
    logic [3:0]  out_bytes_avail;
    logic [31:0] out_offset;
    logic        consume = 1'b0;
    logic [3:0]  consume_len = '0;
    logic        err_consume;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string       tag;
        logic        v;
        logic [3:0]  avail;
        logic [95:0] raw;
        logic [31:0] off;
        logic        rdy;
        logic        err;
    } exp_t;

    exp_t exp_q[$];

    instr_fetch_window dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .flush(flush), .flush_offset(flush_offset),
        .out_valid(out_valid), .out_raw_instr(out_raw_instr),
        .out_bytes_avail(out_bytes_avail), .out_offset(out_offset),
        .consume(consume), .consume_len(consume_len), .err_consume(err_consume)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(string tag, logic v, logic [3:0] avail, logic [95:0] raw,
                                logic [31:0] off, logic rdy, logic err);
        exp_t e;
        e.tag = tag; e.v = v; e.avail = avail; e.raw = raw;
        e.off = off; e.rdy = rdy; e.err = err;
        return e;
    endfunction

    task automatic chk(string tag, logic [95:0] obs, logic [95:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_all(exp_t e);
        chk({e.tag, ".out_valid"}, 96'(out_valid), 96'(e.v));
        chk({e.tag, ".avail"},     96'(out_bytes_avail), 96'(e.avail));
        chk({e.tag, ".raw"},       out_raw_instr, e.raw);
        chk({e.tag, ".offset"},    96'(out_offset), 96'(e.off));
        chk({e.tag, ".in_ready"},  96'(in_ready), 96'(e.rdy));
        chk({e.tag, ".err"},       96'(err_consume), 96'(e.err));
    endtask

    task automatic step(input logic iv, input logic [31:0] d, input logic il,
                        input logic c, input logic [3:0] cl,
                        input logic fl, input logic [31:0] fo, input exp_t e);
        in_valid = iv; in_data = d; in_last = il;
        consume = c; consume_len = cl; flush = fl; flush_offset = fo;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        consume = 1'b0; consume_len = '0; flush = 1'b0; flush_offset = '0;
        tests++;
        assert (exp_q.size() != 0) else begin
            fails++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end
        if (exp_q.size() != 0) check_all(exp_q.pop_front());
    endtask

    initial begin
        #7;
        check_all(mk("in_reset", 0, 0, '0, 0, 0, 0));
        #5 rst_n = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0, mk("post_reset", 0, 0, '0, 0, 1, 0));

        // Fill to a full window
        step(1, 32'h03020100, 0, 0, 0, 0, 0, mk("fill1", 0, 4, 96'h03020100, 0, 1, 0));
        step(1, 32'h07060504, 0, 0, 0, 0, 0, mk("fill2", 0, 8, 96'h0706050403020100, 0, 1, 0));
        step(1, 32'h0B0A0908, 0, 0, 0, 0, 0,
             mk("fill3", 1, 12, 96'h0B0A0908_07060504_03020100, 0, 1, 0));

        // Consume 3 with a same-cycle beat -> count 13
        step(1, 32'h0F0E0D0C, 0, 1, 3, 0, 0,
             mk("overlap", 1, 12, 96'h0E0D0C0B_0A090807_06050403, 3, 0, 0));
        // Beat offered while in_ready low must be dropped
        step(1, 32'hDEADBEEF, 0, 1, 1, 0, 0,
             mk("consume1", 1, 12, 96'h0F0E0D0C_0B0A0908_07060504, 4, 1, 0));
        step(1, 32'h13121110, 0, 0, 0, 0, 0,
             mk("to16", 1, 12, 96'h0F0E0D0C_0B0A0908_07060504, 4, 0, 0));
        step(0, 0, 0, 1, 2, 0, 0,
             mk("to14", 1, 12, 96'h11100F0E_0D0C0B0A_09080706, 6, 0, 0));

        // Flush beats consume and push
        step(1, 32'hCAFEF00D, 0, 1, 2, 1, 32'h1000, mk("flush", 0, 0, '0, 32'h1000, 1, 0));

        // End of stream and drain
        step(1, 32'h04030201, 1, 0, 0, 0, 0, mk("eos", 1, 4, 96'h04030201, 32'h1000, 0, 0));
        step(0, 0, 0, 1, 5, 0, 0, mk("bad_len5", 1, 4, 96'h04030201, 32'h1000, 0, 1));
        step(0, 0, 0, 0, 0, 0, 0, mk("err_clear", 1, 4, 96'h04030201, 32'h1000, 0, 0));
        step(0, 0, 0, 1, 0, 0, 0, mk("bad_len0", 1, 4, 96'h04030201, 32'h1000, 0, 1));
        step(1, 32'h55555555, 0, 0, 0, 0, 0,
             mk("eos_blocks", 1, 4, 96'h04030201, 32'h1000, 0, 0));
        step(0, 0, 0, 1, 4, 0, 0, mk("drained", 0, 0, '0, 32'h1004, 0, 0));
        step(0, 0, 0, 1, 1, 0, 0, mk("bad_novalid", 0, 0, '0, 32'h1004, 0, 1));
        step(0, 0, 0, 0, 0, 0, 0, mk("done_idle", 0, 0, '0, 32'h1004, 0, 0));

        // Offset wrap
        step(0, 0, 0, 0, 0, 1, 32'hFFFFFFFE, mk("flush_wrap", 0, 0, '0, 32'hFFFFFFFE, 1, 0));
        step(1, 32'h33221100, 0, 0, 0, 0, 0,
             mk("wfill1", 0, 4, 96'h33221100, 32'hFFFFFFFE, 1, 0));
        step(1, 32'h77665544, 0, 0, 0, 0, 0,
             mk("wfill2", 0, 8, 96'h7766554433221100, 32'hFFFFFFFE, 1, 0));
        step(1, 32'hBBAA9988, 0, 0, 0, 0, 0,
             mk("wfill3", 1, 12, 96'hBBAA9988_77665544_33221100, 32'hFFFFFFFE, 1, 0));
        step(0, 0, 0, 1, 3, 0, 0,
             mk("wrap", 0, 9, 96'h000000BB_AA998877_66554433, 32'h00000001, 1, 0));

        // Async reset mid-stream
        step(1, 32'hA5A5A5A5, 0, 0, 0, 0, 0,
             mk("pre_rst", 1, 12, 96'hA5A5A5BB_AA998877_66554433, 32'h00000001, 0, 0));
        #2 rst_n = 1'b0;
        #1 check_all(mk("async_rst", 0, 0, '0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0, mk("rst_release", 0, 0, '0, 0, 1, 0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instr_fetch_window.md
Name: instr_fetch_window

Overview:
- Sequences raw instruction bytes into the 96-bit little-endian window that the prefix/opcode decode stage consumes.
- Accepts a 32-bit byte stream with a valid/ready handshake and buffers up to 16 bytes.
- Presents the oldest 12 bytes to decode, then retires however many bytes the decoded instruction used.
- Also tracks the byte offset of the presented instruction, and handles end-of-stream drain and flush.

Parameters:
- WINDOW_BYTES, 12, bytes presented to decode; fixed by the 96-bit decode input.
- IN_BYTES, 4, bytes per input beat (32-bit input word).
- BUF_BYTES, 16, internal buffer capacity; must equal WINDOW_BYTES + IN_BYTES.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data/in_last valid.
- in_ready  output  1  block accepts a beat this cycle.
- in_data  input  32  four instruction bytes; byte 0 in [7:0].
- in_last  input  1  final beat of the stream; qualified by in_valid.
- flush  input  1  discard all buffered bytes and restart.
- flush_offset  input  32  offset loaded on flush.
- out_valid  output  1  window holds a decodable instruction.
- out_raw_instr  output  96  window; buffer byte 0 in [7:0], unfilled bytes zero.
- out_bytes_avail  output  4  valid bytes in window, 0..12.
- out_offset  output  32  stream byte offset of window byte 0.
- consume  input  1  decode retires consume_len bytes.
- consume_len  input  4  bytes retired, legal 1..out_bytes_avail.
- err_consume  output  1  one-cycle pulse on an illegal consume.

Behaviour:
- Reset (async assert, sync release):
  - count=0, eos=0, out_offset=0, buffer zero, err_consume=0, state FILL.
  - out_valid=0, out_bytes_avail=0, out_raw_instr=0.
  - in_ready=0 while rst_n low; 1 from the first cycle after release.
- State (count = buffered bytes 0..16, eos = in_last accepted):
  - FILL: !eos, count<12.
  - PRESENT: count>=12.
  - DRAIN: eos, 0<count<12.
  - DONE: eos, count==0.
  - State is a registered function of the next count and eos, updated every cycle.
  - DONE leaves only via flush, to FILL.
- in_ready = (count<=12) && !eos, registered from next-cycle state. A beat is accepted when in_valid && in_ready.
- out_valid = PRESENT || DRAIN. out_bytes_avail = min(count,12).
- Outputs are driven from registers; an accepted beat is visible on out_* the next cycle (1-cycle latency).
- Legal consume: consume && out_valid && 1<=consume_len<=out_bytes_avail.
  - Next cycle: buffer shifts down by consume_len bytes, vacated high bytes zeroed.
  - count -= consume_len; out_offset += consume_len, wrapping mod 2^32.
- Illegal consume: consume with !out_valid, or consume_len==0, or consume_len>out_bytes_avail.
  - No shift, no offset change.
  - err_consume=1 for exactly the next cycle.
- Simultaneous legal consume and accepted beat, same cycle:
  - Shift first, then append the 4 new bytes at index (count-consume_len).
  - count = count-consume_len+4.
  - No byte is lost or duplicated.
- Capacity:
  - Acceptance requires count<=12, so count never exceeds 16.
  - At count 13..16, in_ready=0 until a consume brings count<=12; in_ready rises the cycle after that consume.
- in_last accepted: eos=1 and in_ready=0 thereafter; the remaining bytes are presented through DRAIN.
- A beat with in_valid=0 has no effect; in_data is ignored when not accepted.
- flush has priority over consume and push in the same cycle:
  - Next cycle: count=0, eos=0, buffer zero, out_offset=flush_offset, state FILL.
  - out_valid=0; err_consume not raised.
  - A simultaneous in_valid beat is dropped (in_ready is treated as 0 for acceptance).
- Reset mid-operation: immediate return to reset values; buffered bytes are lost.

Test Plan:
- Fill: after reset push words 0x03020100, 0x07060504, 0x0B0A0908 -> cycle after third beat out_valid=1, out_bytes_avail=12, out_raw_instr=0x0B0A09080706050403020100, out_offset=0, in_ready=1.
- Consume+push overlap: from the above state push 0x0F0E0D0C together with consume_len=3 -> count=13, window bytes 03..0E, out_offset=3, in_ready=0 next cycle; consume 1 -> in_ready=1.
- Drain/EOS: push 0x04030201 with in_last=1 -> out_valid=1, out_bytes_avail=4, out_raw_instr=0x04030201, in_ready=0; consume 4 -> out_valid=0, state DONE, in_ready stays 0.
- Illegal consume: out_bytes_avail=4, consume_len=5 -> err_consume=1 for one cycle, window and out_offset unchanged; consume with out_valid=0 -> same.
- Flush priority: count=14 with consume=1, consume_len=2, in_valid=1 and flush=1 with flush_offset=0x1000 -> count=0, out_valid=0, out_offset=0x1000, beat dropped, in_ready=1.
- Offset wrap and async reset: flush_offset=0xFFFFFFFE, fill, consume 3 -> out_offset=0x00000001; drop rst_n mid-stream -> all outputs zero immediately.
